// File: rtl/bram_wr_port_arbiter_flat.sv
// bram_wr_port_arbiter_flat
// Registered N-source write-port arbiter in front of a bank of BRAMs.
// Sources raise a level request for a whole burst. The arbiter grants one
// owner, either by fixed priority or by round-robin. The owner keeps the
// port until its request (or the force override) drops. After that, one
// dead TURN cycle separates it from the next owner. The owner's write
// buses are registered onto the BRAM pins and gated by the grant. A
// saturating counter records how many cycles some request was left waiting.
module bram_wr_port_arbiter_flat #(
  parameter int NUM_SRC      = 3,
  parameter int NUM_ELEMENTS = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int SEL_W        = $clog2(NUM_SRC)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      mode,
  input  logic                                      force_en,
  input  logic [SEL_W-1:0]                          force_sel,
  input  logic [NUM_SRC-1:0]                        src_req,
  input  logic [NUM_SRC*NUM_ELEMENTS-1:0]           src_we_flat,
  input  logic [NUM_SRC*NUM_ELEMENTS*ADDR_WIDTH-1:0] src_addr_flat,
  input  logic [NUM_SRC*NUM_ELEMENTS*DATA_WIDTH-1:0] src_din_flat,
  output logic [NUM_SRC-1:0]                        grant,
  output logic                                      busy,
  output logic [NUM_ELEMENTS-1:0]                   bram_we_flat,
  output logic [NUM_ELEMENTS*ADDR_WIDTH-1:0]        bram_addr_flat,
  output logic [NUM_ELEMENTS*DATA_WIDTH-1:0]        bram_din_flat,
  output logic [15:0]                               contention_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [SEL_W-1:0]                owner_q, owner_d;
  logic [SEL_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic                            forced_q, forced_d;
  logic [NUM_SRC-1:0]              grant_q, grant_d;
  logic [SEL_W-1:0]                win;
  logic                            force_ok;

  logic [NUM_ELEMENTS-1:0]            we_p0;
  logic [NUM_ELEMENTS*ADDR_WIDTH-1:0] addr_p0;
  logic [NUM_ELEMENTS*DATA_WIDTH-1:0] din_p0;
  logic [NUM_ELEMENTS-1:0]            we_p1;
  logic [NUM_ELEMENTS*ADDR_WIDTH-1:0] addr_p1;
  logic [NUM_ELEMENTS*DATA_WIDTH-1:0] din_p1;
  logic [15:0]                        cnt_q;
  logic                               pending;

  // Lowest set index wins.
  function automatic logic [SEL_W-1:0] pick_fixed(input logic [NUM_SRC-1:0] req);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  // First set index at or after ptr, wrapping around the source list.
  function automatic logic [SEL_W-1:0] pick_rr(input logic [NUM_SRC-1:0] req,
                                               input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] idx;
    logic             found;
    int               j;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      j = (int'(ptr) + i) % NUM_SRC;
      if (!found && req[j]) begin
        idx   = SEL_W'(j);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Round-robin pointer moves to the source after the releasing owner.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] own);
    return SEL_W'((int'(own) + 1) % NUM_SRC);
  endfunction

  function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_SRC'(1) << idx;
  endfunction

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign force_ok = (int'(force_sel) < NUM_SRC);

  // Arbitration FSM: next state, next owner and next grant.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    forced_d = forced_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    win      = mode ? pick_rr(src_req, rr_ptr_q) : pick_fixed(src_req);
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (force_en) begin
          // An out-of-range force index parks the arbiter in IDLE.
          if (force_ok) begin
            state_d  = GRANT;
            owner_d  = force_sel;
            forced_d = 1'b1;
            grant_d  = onehot(force_sel);
          end
        end else if (|src_req) begin
          state_d  = GRANT;
          owner_d  = win;
          forced_d = 1'b0;
          grant_d  = onehot(win);
        end
      end
      GRANT: begin
        if (forced_q ? !force_en : !src_req[owner_q]) begin
          state_d  = TURN;
          forced_d = 1'b0;
          grant_d  = '0;
          rr_ptr_d = next_ptr(owner_q);
        end
      end
      TURN: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d  = IDLE;
        forced_d = 1'b0;
        grant_d  = '0;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      forced_q <= 1'b0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      forced_q <= forced_d;
      grant_q  <= grant_d;
    end
  end

  // Owner write-bus select; with no grant every field collapses to zero.
  always_comb begin
    we_p0   = '0;
    addr_p0 = '0;
    din_p0  = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (grant_q[s]) begin
        we_p0   = we_p0   | src_we_flat[s*NUM_ELEMENTS +: NUM_ELEMENTS];
        addr_p0 = addr_p0 | src_addr_flat[s*NUM_ELEMENTS*ADDR_WIDTH +: NUM_ELEMENTS*ADDR_WIDTH];
        din_p0  = din_p0  | src_din_flat[s*NUM_ELEMENTS*DATA_WIDTH +: NUM_ELEMENTS*DATA_WIDTH];
      end
    end
  end

  // ---- p0 -> p1: BRAM pin register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_p1   <= '0;
      addr_p1 <= '0;
      din_p1  <= '0;
    end else begin
      we_p1   <= we_p0;
      addr_p1 <= addr_p0;
      din_p1  <= din_p0;
    end
  end

  assign pending = |(src_req & ~grant_q);

  // Saturating count of cycles in which some request was not granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (pending) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign grant          = grant_q;
  assign busy           = (state_q != IDLE);
  assign bram_we_flat   = we_p1;
  assign bram_addr_flat = addr_p1;
  assign bram_din_flat  = din_p1;
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_bram_wr_port_arbiter_flat.sv
// Directed bench for bram_wr_port_arbiter_flat with default parameters
// (3 sources, 16 BRAMs, 16-bit data, 10-bit addresses).
module tb_bram_wr_port_arbiter_flat;

  logic         clk;
  logic         rst_n;
  logic         mode;
  logic         force_en;
  logic [1:0]   force_sel;
  logic [2:0]   src_req;
  logic [47:0]  src_we_flat;
  logic [479:0] src_addr_flat;
  logic [767:0] src_din_flat;
  logic [2:0]   grant;
  logic         busy;
  logic [15:0]  bram_we_flat;
  logic [159:0] bram_addr_flat;
  logic [255:0] bram_din_flat;
  logic [15:0]  contention_cnt;

  int checks;
  int errors;

  bram_wr_port_arbiter_flat dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mode           (mode),
    .force_en       (force_en),
    .force_sel      (force_sel),
    .src_req        (src_req),
    .src_we_flat    (src_we_flat),
    .src_addr_flat  (src_addr_flat),
    .src_din_flat   (src_din_flat),
    .grant          (grant),
    .busy           (busy),
    .bram_we_flat   (bram_we_flat),
    .bram_addr_flat (bram_addr_flat),
    .bram_din_flat  (bram_din_flat),
    .contention_cnt (contention_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Element e of source s gets address a+e and data d+e.
  task automatic drive_src(input int s, input logic [15:0] we,
                           input logic [9:0] a, input logic [15:0] d);
    for (int e = 0; e < 16; e++) begin
      src_we_flat[s*16 + e]              = we[e];
      src_addr_flat[(s*16 + e)*10 +: 10] = a + 10'(e);
      src_din_flat[(s*16 + e)*16 +: 16]  = d + 16'(e);
    end
  endtask

  function automatic logic [159:0] exp_addr(input logic [9:0] a);
    logic [159:0] r;
    for (int e = 0; e < 16; e++) r[e*10 +: 10] = a + 10'(e);
    return r;
  endfunction

  function automatic logic [255:0] exp_din(input logic [15:0] d);
    logic [255:0] r;
    for (int e = 0; e < 16; e++) r[e*16 +: 16] = d + 16'(e);
    return r;
  endfunction

  initial begin
    logic [2:0] rr_exp [4];
    int own;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    mode          = 1'b0;
    force_en      = 1'b0;
    force_sel     = 2'd0;
    src_req       = 3'b111;
    src_we_flat   = '0;
    src_addr_flat = '0;
    src_din_flat  = '0;

    // Reset held with every source requesting.
    step();
    step();
    chk("rst_grant", 256'(grant), 256'(3'b000));
    chk("rst_busy", 256'(busy), 256'(1'b0));
    chk("rst_we", 256'(bram_we_flat), 256'(16'h0));
    chk("rst_addr", 256'(bram_addr_flat), 256'(0));
    chk("rst_din", bram_din_flat, 256'(0));
    chk("rst_cnt", 256'(contention_cnt), 256'(16'd0));

    rst_n = 1'b1;
    step();
    chk("post_rst_grant", 256'(grant), 256'(3'b001));
    chk("post_rst_busy", 256'(busy), 256'(1'b1));
    chk("post_rst_cnt", 256'(contention_cnt), 256'(16'd1));
    src_req = 3'b000;
    step();
    chk("rel_grant", 256'(grant), 256'(3'b000));
    chk("rel_turn_busy", 256'(busy), 256'(1'b1));
    step();
    chk("idle_busy", 256'(busy), 256'(1'b0));

    // Fixed priority: source 1 beats source 2, then a 4-write burst.
    src_req = 3'b110;
    drive_src(2, 16'hFFFF, 10'd100, 16'h0500);
    step();
    chk("fp_grant", 256'(grant), 256'(3'b010));
    chk("fp_cnt0", 256'(contention_cnt), 256'(16'd2));
    for (int k = 0; k < 4; k++) begin
      drive_src(1, 16'hFFFF, 10'(k), 16'h00A0 + 16'(k));
      step();
      chk("fp_we", 256'(bram_we_flat), 256'(16'hFFFF));
      chk("fp_addr", 256'(bram_addr_flat), 256'(exp_addr(10'(k))));
      chk("fp_din", bram_din_flat, exp_din(16'h00A0 + 16'(k)));
    end
    chk("fp_cnt_burst", 256'(contention_cnt), 256'(16'd6));
    src_req = 3'b100;
    drive_src(1, 16'h0000, 10'd0, 16'h0000);
    step();
    chk("fp_rel_grant", 256'(grant), 256'(3'b000));
    chk("fp_rel_we", 256'(bram_we_flat), 256'(16'h0));
    step();
    chk("fp_turn_grant", 256'(grant), 256'(3'b000));
    chk("gate_we", 256'(bram_we_flat), 256'(16'h0));
    step();
    chk("fp_grant2", 256'(grant), 256'(3'b100));
    chk("fp_cnt_wait", 256'(contention_cnt), 256'(16'd9));
    step();
    chk("fp_src2_we", 256'(bram_we_flat), 256'(16'hFFFF));
    chk("fp_src2_addr", 256'(bram_addr_flat), 256'(exp_addr(10'd100)));
    chk("fp_src2_din", bram_din_flat, exp_din(16'h0500));
    chk("fp_cnt_hold", 256'(contention_cnt), 256'(16'd9));
    src_req = 3'b000;
    drive_src(2, 16'h0000, 10'd0, 16'h0000);
    step();
    step();

    // Round-robin with all three sources requesting; pointer starts at 0.
    mode      = 1'b1;
    src_req   = 3'b111;
    rr_exp[0] = 3'b001;
    rr_exp[1] = 3'b010;
    rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001;
    for (int k = 0; k < 4; k++) begin
      own = k % 3;
      step();
      chk("rr_grant", 256'(grant), 256'(rr_exp[k]));
      step();
      chk("rr_hold", 256'(grant), 256'(rr_exp[k]));
      src_req[own] = 1'b0;
      step();
      chk("rr_turn_grant", 256'(grant), 256'(3'b000));
      chk("rr_turn_busy", 256'(busy), 256'(1'b1));
      src_req[own] = 1'b1;
      step();
      chk("rr_idle_grant", 256'(grant), 256'(3'b000));
    end
    src_req = 3'b000;
    mode    = 1'b0;

    // Forced grant with no requests.
    force_en  = 1'b1;
    force_sel = 2'd2;
    step();
    chk("force_grant", 256'(grant), 256'(3'b100));
    drive_src(2, 16'hFFFF, 10'd200, 16'h0700);
    step();
    chk("force_hold", 256'(grant), 256'(3'b100));
    step();
    chk("force_addr", 256'(bram_addr_flat), 256'(exp_addr(10'd200)));
    chk("force_din", bram_din_flat, exp_din(16'h0700));
    force_en = 1'b0;
    drive_src(2, 16'h0000, 10'd0, 16'h0000);
    step();
    chk("force_rel", 256'(grant), 256'(3'b000));
    step();

    // Out-of-range force index parks the arbiter even with a request.
    force_en  = 1'b1;
    force_sel = 2'd3;
    drive_src(0, 16'hFFFF, 10'd300, 16'h0900);
    step();
    chk("force_oor_grant", 256'(grant), 256'(3'b000));
    chk("force_oor_busy", 256'(busy), 256'(1'b0));
    src_req = 3'b001;
    step();
    chk("force_oor_req_grant", 256'(grant), 256'(3'b000));
    chk("force_oor_we", 256'(bram_we_flat), 256'(16'h0));
    force_en = 1'b0;
    step();
    chk("unforce_grant", 256'(grant), 256'(3'b001));
    chk("unforce_we_gated", 256'(bram_we_flat), 256'(16'h0));
    step();
    chk("src0_we", 256'(bram_we_flat), 256'(16'hFFFF));
    chk("src0_addr", 256'(bram_addr_flat), 256'(exp_addr(10'd300)));

    // Reset in the middle of the source-0 burst.
    rst_n = 1'b0;
    step();
    chk("mid_rst_we", 256'(bram_we_flat), 256'(16'h0));
    chk("mid_rst_grant", 256'(grant), 256'(3'b000));
    chk("mid_rst_busy", 256'(busy), 256'(1'b0));
    chk("mid_rst_cnt", 256'(contention_cnt), 256'(16'd0));
    rst_n   = 1'b1;
    src_req = 3'b000;
    drive_src(0, 16'h0000, 10'd0, 16'h0000);
    step();
    chk("post_mid_rst_grant", 256'(grant), 256'(3'b000));

    // Saturation: source 0 holds the port while source 1 waits.
    src_req = 3'b011;
    repeat (65534) step();
    chk("sat_fffe", 256'(contention_cnt), 256'(16'hFFFE));
    step();
    chk("sat_ffff", 256'(contention_cnt), 256'(16'hFFFF));
    repeat (4500) step();
    chk("sat_hold", 256'(contention_cnt), 256'(16'hFFFF));
    chk("sat_no_preempt", 256'(grant), 256'(3'b001));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
